parity_accum: RTL and testbench

- Parametrised, clocked successor to the 3-input XOR cell.
- Reduces a WIDTH-bit input word to one parity bit every cycle and accumulates that parity across a framed stream of up to MAXLEN words.
- Reports the frame parity, the frame length and an error flag one cycle after end of frame.
- Two modes: generate only, or check against an expected parity bit.
- Sits on serial/bus interfaces of the lsi_10k-based datapath as a frame parity generator/checker.

---
 rtl/parity_pkg.sv | 26 ++
 rtl/parity_tree.sv | 81 ++++++++
 rtl/parity_accum.sv | 124 ++++++++++++
 tb/tb_parity_accum.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// ============================================================================
//  Module   : parity_pkg
//  Purpose  : Shared state encodings, mode encodings and sizing helper for
//             the frame parity generator/checker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t ACCUM = 1'b1;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Length counter must be able to hold MAXLEN itself, not just MAXLEN-1.
    function automatic int calc_cw(input int maxlen);
        return $clog2(maxlen + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/parity_tree.sv
// ============================================================================
//  Module   : parity_tree
//  Purpose  : Combinational reduction of a WIDTH-bit word to its parity bit
//             using levels of 3-input XOR cells.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_tree #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] D,
    output logic             wp
);

    function automatic int lvl_cnt(input int w, input int lvl);
        int n;
        n = w;
        for (int i = 0; i < lvl; i++) n = (n + 2) / 3;
        return n;
    endfunction

    function automatic int num_lvls(input int w);
        int n;
        int k;
        n = w;
        k = 0;
        while (n > 1) begin
            n = (n + 2) / 3;
            k++;
        end
        return k;
    endfunction

    function automatic logic xor3(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    localparam int LEVELS = num_lvls(WIDTH);

    generate
        if (LEVELS == 0) begin : g_passthru
            assign wp = D[0];
        end else begin : g_tree
            for (genvar l = 0; l < LEVELS; l++) begin : g_level
                localparam int N_IN  = lvl_cnt(WIDTH, l);
                localparam int N_OUT = lvl_cnt(WIDTH, l + 1);

                logic [N_IN-1:0]  w_in;
                logic [N_OUT-1:0] w_out;

                if (l == 0) begin : g_first
                    assign w_in = D;
                end else begin : g_next
                    assign w_in = g_level[l-1].w_out;
                end

                // The last cell of a level may see fewer than three live inputs.
                for (genvar j = 0; j < N_OUT; j++) begin : g_node
                    logic w_b;
                    logic w_c;
                    if (3*j + 1 < N_IN) begin : g_b_live
                        assign w_b = w_in[3*j+1];
                    end else begin : g_b_pad
                        assign w_b = 1'b0;
                    end
                    if (3*j + 2 < N_IN) begin : g_c_live
                        assign w_c = w_in[3*j+2];
                    end else begin : g_c_pad
                        assign w_c = 1'b0;
                    end
                    assign w_out[j] = xor3(w_in[3*j], w_b, w_c);
                end
            end
            assign wp = g_level[LEVELS-1].w_out[0];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/parity_accum.sv
// ============================================================================
//  Module   : parity_accum
//  Purpose  : Framed parity generator/checker; accumulates word parity over a
//             frame and reports parity, length and error after end of frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module parity_accum
    import parity_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MAXLEN = 16,
    parameter int ODD    = 0,
    parameter int CW     = calc_cw(MAXLEN)
) (
    input  logic             CP,
    input  logic             CD,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    input  logic             SOF,
    input  logic             EOF,
    input  logic             MODE,
    input  logic             PE,
    output logic             Z,
    output logic             ZV,
    output logic [CW-1:0]    LEN,
    output logic             ERR,
    output logic             BUSY
);

    localparam logic [CW-1:0] c_maxlen = CW'(MAXLEN);
    localparam logic [CW-1:0] c_one    = CW'(1);
    localparam logic          c_odd    = (ODD != 0);

    state_t          r_state;
    logic            r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_z;
    logic            r_zv;
    logic [CW-1:0]   r_len;
    logic            r_err;

    state_t          w_state_n;
    logic            w_acc_n;
    logic [CW-1:0]   w_cnt_n;
    logic            w_done;
    logic            w_len_err;
    logic            w_z_new;
    logic            w_err_new;
    logic            w_wp;

    parity_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .D  (D),
        .wp (w_wp)
    );

    // A SOF word always opens a fresh frame, whether idle or mid-frame, so
    // the termination checks are shared by both entry paths.
    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_cnt_n   = r_cnt;
        w_done    = 1'b0;
        w_len_err = 1'b0;
        if (DV) begin
            if (SOF) begin
                w_acc_n = w_wp;
                w_cnt_n = c_one;
            end else if (r_state == ACCUM) begin
                w_acc_n = r_acc ^ w_wp;
                w_cnt_n = r_cnt + c_one;
            end
            if (SOF || (r_state == ACCUM)) begin
                if (EOF) begin
                    w_done    = 1'b1;
                    w_state_n = IDLE;
                end else if (w_cnt_n == c_maxlen) begin
                    w_done    = 1'b1;
                    w_len_err = 1'b1;
                    w_state_n = IDLE;
                end else begin
                    w_state_n = ACCUM;
                end
            end
        end
    end

    assign w_z_new   = w_acc_n ^ c_odd;
    assign w_err_new = w_len_err | ((MODE == MODE_CHK) && (w_z_new != PE));

    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_state <= IDLE;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            r_z     <= 1'b0;
            r_zv    <= 1'b0;
            r_len   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_cnt   <= w_cnt_n;
            r_zv    <= w_done;
            if (w_done) begin
                r_z   <= w_z_new;
                r_len <= w_cnt_n;
                r_err <= w_err_new;
            end
        end
    end

    assign Z    = r_z;
    assign ZV   = r_zv;
    assign LEN  = r_len;
    assign ERR  = r_err;
    assign BUSY = (r_state == ACCUM);

endmodule

`default_nettype wire

// File: tb/tb_parity_accum.sv
// ============================================================================
//  Module   : tb_parity_accum
//  Purpose  : Directed bench for parity_accum (WIDTH=8, MAXLEN=4), even and
//             odd parity instances driven in parallel.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_parity_accum;

    logic       CP;
    logic       CD;
    logic [7:0] D;
    logic       DV, SOF, EOF, MODE, PE;

    logic       z0, zv0, err0, busy0;
    logic [2:0] len0;
    logic       z1, zv1, err1, busy1;
    logic [2:0] len1;

    int n_checks = 0;
    int n_errors = 0;

    parity_accum #(.WIDTH(8), .MAXLEN(4), .ODD(0)) dut_even (
        .CP(CP), .CD(CD), .D(D), .DV(DV), .SOF(SOF), .EOF(EOF),
        .MODE(MODE), .PE(PE),
        .Z(z0), .ZV(zv0), .LEN(len0), .ERR(err0), .BUSY(busy0)
    );

    parity_accum #(.WIDTH(8), .MAXLEN(4), .ODD(1)) dut_odd (
        .CP(CP), .CD(CD), .D(D), .DV(DV), .SOF(SOF), .EOF(EOF),
        .MODE(MODE), .PE(PE),
        .Z(z1), .ZV(zv1), .LEN(len1), .ERR(err1), .BUSY(busy1)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    typedef struct {
        logic       dv, sof, eof, mode, pe;
        logic [7:0] d;
        logic       zv, z;
        logic [2:0] len;
        logic       err, busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic dv, sof, eof, mode, pe, input logic [7:0] d,
                       input logic zv, z, input logic [2:0] len, input logic err, busy);
        vec_t v;
        v.dv = dv; v.sof = sof; v.eof = eof; v.mode = mode; v.pe = pe; v.d = d;
        v.zv = zv; v.z = z; v.len = len; v.err = err; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic dv, sof, eof, mode, pe, input logic [7:0] d);
        @(negedge CP);
        DV = dv; SOF = sof; EOF = eof; MODE = mode; PE = pe; D = d;
        @(posedge CP);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic zv, z, input logic [2:0] len,
                           input logic err, busy, input bit odd_dut);
        if (odd_dut) begin
            chk({tag, "_zv"},   zv1,   zv);
            chk({tag, "_z"},    z1,    z);
            chk({tag, "_len"},  len1,  len);
            chk({tag, "_err"},  err1,  err);
            chk({tag, "_busy"}, busy1, busy);
        end else begin
            chk({tag, "_zv"},   zv0,   zv);
            chk({tag, "_z"},    z0,    z);
            chk({tag, "_len"},  len0,  len);
            chk({tag, "_err"},  err0,  err);
            chk({tag, "_busy"}, busy0, busy);
        end
    endtask

    initial begin
        CD = 1'b0; DV = 0; SOF = 0; EOF = 0; MODE = 0; PE = 0; D = '0;

        //   dv sof eof md pe  d        zv z len err busy
        add(1, 1, 0, 0, 0, 8'h01,   0, 0, 3'd0, 0, 1);
        add(1, 0, 0, 0, 0, 8'h03,   0, 0, 3'd0, 0, 1);
        add(1, 0, 1, 0, 0, 8'h07,   1, 0, 3'd3, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00,   0, 0, 3'd3, 0, 0);
        add(1, 1, 0, 0, 0, 8'h01,   0, 0, 3'd3, 0, 1);
        add(1, 0, 0, 0, 0, 8'h03,   0, 0, 3'd3, 0, 1);
        add(1, 0, 1, 1, 1, 8'h07,   1, 0, 3'd3, 1, 0);
        add(1, 1, 0, 0, 0, 8'h01,   0, 0, 3'd3, 1, 1);
        add(1, 0, 0, 0, 0, 8'h03,   0, 0, 3'd3, 1, 1);
        add(1, 0, 1, 1, 0, 8'h07,   1, 0, 3'd3, 0, 0);
        add(1, 1, 0, 0, 0, 8'h01,   0, 0, 3'd3, 0, 1);
        add(1, 0, 0, 0, 0, 8'h00,   0, 0, 3'd3, 0, 1);
        add(1, 0, 0, 0, 0, 8'h00,   0, 0, 3'd3, 0, 1);
        add(1, 0, 0, 0, 0, 8'h00,   1, 1, 3'd4, 1, 0);
        add(1, 1, 0, 0, 0, 8'h03,   0, 1, 3'd4, 1, 1);
        add(1, 0, 1, 0, 0, 8'h03,   1, 0, 3'd2, 0, 0);
        add(1, 1, 1, 0, 0, 8'hFF,   1, 0, 3'd1, 0, 0);
        add(1, 1, 1, 0, 0, 8'h80,   1, 1, 3'd1, 0, 0);
        add(1, 1, 1, 0, 0, 8'h00,   1, 0, 3'd1, 0, 0);
        add(1, 1, 0, 0, 0, 8'h01,   0, 0, 3'd1, 0, 1);
        add(1, 1, 0, 0, 0, 8'h02,   0, 0, 3'd1, 0, 1);
        add(1, 0, 1, 0, 0, 8'h02,   1, 0, 3'd2, 0, 0);
        add(1, 0, 0, 0, 0, 8'h55,   0, 0, 3'd2, 0, 0);
        add(1, 0, 1, 1, 1, 8'h01,   0, 0, 3'd2, 0, 0);
        add(1, 1, 0, 0, 0, 8'h01,   0, 0, 3'd2, 0, 1);
        add(1, 0, 0, 0, 0, 8'h01,   0, 0, 3'd2, 0, 1);
        add(0, 1, 1, 0, 0, 8'hFF,   0, 0, 3'd2, 0, 1);
        add(1, 0, 0, 0, 0, 8'h01,   0, 0, 3'd2, 0, 1);
        add(1, 0, 1, 1, 1, 8'h00,   1, 1, 3'd4, 0, 0);

        #2;
        chk_all("rst_even", 0, 0, 3'd0, 0, 0, 0);
        chk_all("rst_odd",  0, 0, 3'd0, 0, 0, 1);
        @(negedge CP);
        CD = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].dv, vecs[i].sof, vecs[i].eof, vecs[i].mode, vecs[i].pe, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].zv, vecs[i].z, vecs[i].len,
                    vecs[i].err, vecs[i].busy, 0);
        end

        // Load nonzero history, open a frame to cnt=2, then reset between edges.
        step(1, 1, 1, 1, 0, 8'h01);
        chk_all("pre_rst", 1, 1, 3'd1, 1, 0, 0);
        step(1, 1, 0, 0, 0, 8'h01);
        step(1, 0, 0, 0, 0, 8'h00);
        chk_all("mid_frame", 0, 1, 3'd1, 1, 1, 0);
        #2;
        CD = 1'b0;
        #1;
        chk_all("async_rst_even", 0, 0, 3'd0, 0, 0, 0);
        chk_all("async_rst_odd",  0, 0, 3'd0, 0, 0, 1);
        @(posedge CP);
        @(negedge CP);
        CD = 1'b1;
        step(0, 0, 0, 0, 0, 8'h00);
        chk_all("post_rst_even", 0, 0, 3'd0, 0, 0, 0);
        chk_all("post_rst_odd",  0, 0, 3'd0, 0, 0, 1);

        step(1, 1, 1, 0, 0, 8'h01);
        chk_all("odd_w01", 1, 0, 3'd1, 0, 0, 1);
        chk("even_w01_z", z0, 1);
        step(1, 1, 1, 0, 0, 8'h00);
        chk_all("odd_w00", 1, 1, 3'd1, 0, 0, 1);
        chk("even_w00_z", z0, 0);
        step(1, 1, 1, 1, 1, 8'h00);
        chk_all("odd_chk", 1, 1, 3'd1, 0, 0, 1);
        chk("even_chk_err", err0, 1);
        step(0, 0, 0, 0, 0, 8'h00);
        chk("odd_zv_drop", zv1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
